// File: rtl/sriz_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sriz_pkg
// Description : Shared opcodes, FSM state encoding and immediate decoders
//               for the sriz multi-cycle RV32 core.
// Revision    : 1.0 - initial release
// ============================================================================
package sriz_pkg;

    // Major opcodes understood by the core
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // The only SYSTEM encoding accepted
    localparam logic [31:0] INST_EBREAK = 32'h00100073;

    // Core sequencing states
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    // I-type immediate, sign-extended
    function automatic logic [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    // U-type immediate, already shifted into the upper 20 bits
    function automatic logic [31:0] imm_u(input logic [31:0] inst);
        return {inst[31:12], 12'b0};
    endfunction

    // J-type immediate, sign-extended, bit 0 always zero
    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sriz_regfile.sv
`default_nettype none
// ============================================================================
// Module      : sriz_regfile
// Description : Architectural register file. Two combinational read ports,
//               one synchronous write port, x0 reads as zero, asynchronous
//               active-low clear of every entry.
// Revision    : 1.0 - initial release
// ============================================================================
module sriz_regfile #(
    parameter  int NR_REGS = 32,
    parameter  int XLEN    = 32,
    localparam int REG_AW  = $clog2(NR_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [REG_AW-1:0] i_raddr_a,
    output logic [XLEN-1:0]   o_rdata_a,
    input  logic [REG_AW-1:0] i_raddr_b,
    output logic [XLEN-1:0]   o_rdata_b
);
    import sriz_pkg::*;

    logic [XLEN-1:0] r_regs [NR_REGS];

    // Write port; writes to x0 are dropped so entry 0 stays at its clear value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NR_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_regs[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_regs[i_raddr_b];

endmodule
`default_nettype wire

// File: rtl/sriz_mc.sv
`default_nettype none
// ============================================================================
// Module      : sriz_mc
// Description : Multi-cycle RV32I/RV32E core top. Fetches over a valid/ready
//               instruction bus, sequences FETCH -> WAIT -> EXEC, and parks
//               in a sticky HALT on ebreak or an illegal instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module sriz_mc #(
    parameter  logic [31:0] RESET_PC = 32'h80000000,
    parameter  int          NR_REGS  = 32,
    localparam int          REG_AW   = $clog2(NR_REGS)
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        retire_valid,
    output logic [31:0] retire_pc,
    output logic [31:0] retire_inst,
    output logic        halt,
    output logic        halt_trap,
    output logic [31:0] halt_code
);
    import sriz_pkg::*;

    localparam logic [REG_AW-1:0] c_REG_A0 = REG_AW'(10);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_req_valid;
    logic        r_halt;
    logic        r_halt_trap;
    logic [31:0] r_halt_code;

    // Instruction fields
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd_f;
    logic [4:0]  w_rs1_f;
    logic [2:0]  w_f3;
    logic        w_rd_oob;
    logic        w_rs1_oob;

    // Execute results
    logic [31:0] w_rs1_val;
    logic [31:0] w_x10_val;
    logic        w_legal;
    logic        w_is_ebreak;
    logic        w_uses_rd;
    logic        w_uses_rs1;
    logic [31:0] w_wdata;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_tgt;
    logic        w_rf_we;

    assign w_opcode = r_inst[6:0];
    assign w_rd_f   = r_inst[11:7];
    assign w_f3     = r_inst[14:12];
    assign w_rs1_f  = r_inst[19:15];

    // With 16 registers any index with bit 4 set names a missing register
    generate
        if (NR_REGS < 32) begin : g_rv32e
            assign w_rd_oob  = w_rd_f[4];
            assign w_rs1_oob = w_rs1_f[4];
        end else begin : g_rv32i
            assign w_rd_oob  = 1'b0;
            assign w_rs1_oob = 1'b0;
        end
    endgenerate

    sriz_regfile #(
        .NR_REGS (NR_REGS),
        .XLEN    (32)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_rf_we),
        .i_waddr   (w_rd_f[REG_AW-1:0]),
        .i_wdata   (w_wdata),
        .i_raddr_a (w_rs1_f[REG_AW-1:0]),
        .o_rdata_a (w_rs1_val),
        .i_raddr_b (c_REG_A0),
        .o_rdata_b (w_x10_val)
    );

    // Decode and execute the latched instruction; legality folds in register range and jump alignment
    always_comb begin
        w_legal     = 1'b0;
        w_is_ebreak = 1'b0;
        w_uses_rd   = 1'b0;
        w_uses_rs1  = 1'b0;
        w_wdata     = '0;
        w_tgt       = '0;
        w_pc_nxt    = r_pc + 32'd4;
        case (w_opcode)
            OP_IMM: begin
                if (w_f3 == 3'b000) begin
                    w_legal    = 1'b1;
                    w_uses_rd  = 1'b1;
                    w_uses_rs1 = 1'b1;
                    w_wdata    = w_rs1_val + imm_i(r_inst);
                end
            end
            OP_LUI: begin
                w_legal   = 1'b1;
                w_uses_rd = 1'b1;
                w_wdata   = imm_u(r_inst);
            end
            OP_AUIPC: begin
                w_legal   = 1'b1;
                w_uses_rd = 1'b1;
                w_wdata   = r_pc + imm_u(r_inst);
            end
            OP_JAL: begin
                w_tgt     = r_pc + imm_j(r_inst);
                w_legal   = ~w_tgt[1];
                w_uses_rd = 1'b1;
                w_wdata   = r_pc + 32'd4;
                w_pc_nxt  = w_tgt;
            end
            OP_JALR: begin
                if (w_f3 == 3'b000) begin
                    // rs1 is sampled combinationally, so rd==rs1 sees the old value
                    w_tgt      = (w_rs1_val + imm_i(r_inst)) & ~32'd1;
                    w_legal    = ~w_tgt[1];
                    w_uses_rd  = 1'b1;
                    w_uses_rs1 = 1'b1;
                    w_wdata    = r_pc + 32'd4;
                    w_pc_nxt   = w_tgt;
                end
            end
            OP_SYSTEM: begin
                if (r_inst == INST_EBREAK) begin
                    w_legal     = 1'b1;
                    w_is_ebreak = 1'b1;
                end
            end
            default: begin
            end
        endcase
        if ((w_uses_rd && w_rd_oob) || (w_uses_rs1 && w_rs1_oob)) begin
            w_legal = 1'b0;
        end
    end

    assign w_rf_we = (r_state == EXEC) && w_legal && w_uses_rd;

    // Next-state selection for the fetch/execute sequencer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FETCH:   if (r_req_valid && imem_req_ready) w_state_nxt = WAIT;
            WAIT:    if (imem_rsp_valid) w_state_nxt = EXEC;
            EXEC:    w_state_nxt = (!w_legal || w_is_ebreak) ? HALT : FETCH;
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = FETCH;
        endcase
    end

    // Sequencer state, pc, instruction latch and halt status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= FETCH;
            r_pc        <= RESET_PC;
            r_inst      <= '0;
            r_req_valid <= 1'b0;
            r_halt      <= 1'b0;
            r_halt_trap <= 1'b0;
            r_halt_code <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Request valid is registered so it stays low throughout reset and rises one cycle after
            r_req_valid <= (w_state_nxt == FETCH);
            if ((r_state == WAIT) && imem_rsp_valid) begin
                r_inst <= imem_rsp_data;
            end
            if (r_state == EXEC) begin
                if (w_legal) begin
                    r_pc <= w_pc_nxt;
                end
                if (!w_legal || w_is_ebreak) begin
                    r_halt      <= 1'b1;
                    r_halt_trap <= ~w_legal;
                    r_halt_code <= w_x10_val;
                end
            end
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_pc;
    assign retire_valid   = (r_state == EXEC) && w_legal;
    assign retire_pc      = r_pc;
    assign retire_inst    = r_inst;
    assign halt           = r_halt;
    assign halt_trap      = r_halt_trap;
    assign halt_code      = r_halt_code;

endmodule
`default_nettype wire

// File: doc/sriz_mc.md
Name: sriz_mc

Overview:
Multi-cycle RV32 core top, the successor to the single-cycle sriz top. It has a parametrised reset vector and register count (RV32I/RV32E), and fetches over a valid/ready instruction bus instead of a combinational IFU. An FSM sequences FETCH, WAIT and EXEC, and there is a sticky HALT state for ebreak and illegal instructions. Retire outputs feed the difftest/trace harness.

Parameters:
RESET_PC, 32'h80000000, PC value after reset.
NR_REGS, 32, architectural register count; legal values are 16 or 32.
REG_AW, $clog2(NR_REGS), register index width (derived; do not override).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  memory accepts request.
imem_req_addr  out  32  fetch address (= pc).
imem_rsp_valid  in  1  instruction data valid (single-cycle pulse).
imem_rsp_data  in  32  instruction word.
retire_valid  out  1  one-cycle pulse per retired instruction.
retire_pc  out  32  pc of retired instruction.
retire_inst  out  32  retired instruction word.
halt  out  1  core halted (sticky).
halt_trap  out  1  1 = illegal-instruction halt; 0 = ebreak.
halt_code  out  32  x10 (a0) value captured at halt.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=FETCH, all regs=0, inst latch=0.
- Outputs during reset: imem_req_valid=0, retire_valid=0, halt=0, halt_trap=0, halt_code=0. imem_req_valid rises in the first cycle after rst deasserts.
- FETCH:
  - imem_req_valid=1, imem_req_addr=pc.
  - addr and valid held stable until imem_req_ready=1.
  - On valid&&ready go to WAIT.
  - imem_rsp_valid seen in FETCH is ignored.
- WAIT: on imem_rsp_valid latch imem_rsp_data into inst and go to EXEC; otherwise stay (unbounded).
- EXEC (single cycle): decode, read rs1, execute, write rd, update pc, then go to FETCH.
  - retire_valid=1 in this cycle, with retire_pc=pc and retire_inst=inst.
- Minimum latency is 3 cycles per instruction: req accepted in cycle n, rsp in n+1, EXEC in n+2.
- Supported instructions (anything else is illegal):
  - ADDI: rd = rs1 + sext(imm12).
  - LUI: rd = imm20<<12.
  - AUIPC: rd = pc + (imm20<<12).
  - JAL: rd = pc+4; pc = pc + sext(J-imm).
  - JALR, func3=000 only: target = (rs1 + sext(imm12)) & ~1; rd = pc+4; pc = target. rs1 is read before rd is written, so rd==rs1 is safe.
  - EBREAK: exactly 32'h00100073.
  - All other instructions: pc = pc+4.
- Arithmetic is mod 2^32; pc wraps 32'hFFFFFFFC to 0.
- x0: reads return 0 and writes are dropped.
- Illegal conditions (no rd write, no retire pulse, halt=1, halt_trap=1, halt_code = current x10, pc unchanged, go to HALT):
  - Unknown opcode.
  - JALR func3≠0.
  - Any rd/rs1 index ≥ NR_REGS.
  - JAL/JALR target with bit1 set (misaligned).
- EBREAK: retire pulse asserted, halt=1, halt_trap=0, halt_code=x10, go to HALT.
- HALT: absorbing until reset. imem_req_valid=0, no retire pulses, register file frozen.
- Reset mid-operation (any state, including an in-flight request in WAIT): abandon everything. A late imem_rsp_valid after reset arrives while in FETCH and is ignored; the first new request is to RESET_PC.

Decomposition:
- Package sriz_pkg holds:
  - opcode localparams: OP_IMM 7'b0010011, LUI 7'b0110111, AUIPC 7'b0010111, JAL 7'b1101111, JALR 7'b1100111, SYSTEM 7'b1110011;
  - INST_EBREAK 32'h00100073;
  - state enum {FETCH, WAIT, EXEC, HALT};
  - immediate-extraction functions (I/U/J).
- Sub-module sriz_regfile #(NR_REGS, 32): 2 combinational read ports, 1 sync write port, x0 hardwired to zero, async active-low clear.

Test Plan:
- Memory with ready=1 and 1-cycle response, program ADDI x10,x0,5 (0x00500513) then EBREAK -> two retire pulses (pc 0x80000000, 0x80000004); halt=1, halt_trap=0, halt_code=5; no further requests.
- LUI x2,0x12345 then AUIPC x3,1 at 0x80000004 -> x2=0x12345000, x3=0x80001004.
- JAL x1,+8 at 0x80000000 -> x1=0x80000004; next req addr 0x80000008. JALR x1,0(x1) with x1=0x80000011 -> next addr 0x80000010, x1=pc+4.
- Backpressure: imem_req_ready=0 for 3 cycles -> valid stays 1 and addr constant; exactly one accepted request; correct retire afterwards.
- Inst 0x00000000 -> no retire, halt=1, halt_trap=1, pc unchanged. Build with NR_REGS=16 and ADDI x20,x0,1 -> same trap.
- Assert rst while in WAIT, then deliver a stale rsp_valid one cycle after release -> ignored; first request after release to 0x80000000; all registers 0.
